mem_port_arbiter: RTL and testbench

//  Shares the single-port 1KB byte-addressed data/instruction memory between the pipeline's

---
 rtl/mem_port_arbiter_pkg.sv | 29 ++
 rtl/mem_port_arbiter_if.sv | 36 +++
 rtl/mem_port_arbiter_rr_arb2.sv | 38 +++
 rtl/mem_port_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory-port arbiter.
// State encodings, port ids, word-alignment mask and latched request metadata.
package mem_port_arbiter_pkg;

  localparam int ARB_MEM_BYTES = 1024;
  localparam int ARB_AW        = 32;
  localparam int ARB_DW        = 32;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } arb_state_e;

  localparam logic ID_DATA  = 1'b0;
  localparam logic ID_FETCH = 1'b1;

  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  typedef struct packed {
    logic id;
    logic we;
    logic err;
  } req_meta_t;

  function automatic logic word_aligned(input logic [1:0] lsb);
    return (lsb & WORD_ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request, response and memory-side signals of the memory-port arbiter.
// slave = arbiter side, master = pipeline requesters plus memory.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          rsp_valid;
  logic          rsp_id;
  logic          rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rd;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rd,
    output i_gnt, d_gnt, rsp_valid, rsp_id, rsp_err, rsp_rdata,
           mem_read, mem_write, mem_addr, mem_wd
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rd,
    input  i_gnt, d_gnt, rsp_valid, rsp_id, rsp_err, rsp_rdata,
           mem_read, mem_write, mem_addr, mem_wd
  );
endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; grant is combinational from req when en is high.
// Priority flips to the other port on every issued grant; no backpressure of its own.
module rr_arb2
  import mem_port_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt   = 2'b00;
    ptr_d = ptr_q;
    if (en) begin
      if (req == 2'b11) begin
        gnt = (ptr_q == ID_FETCH) ? 2'b10 : 2'b01;
      end else begin
        gnt = req;
      end
    end
    if (gnt != 2'b00) begin
      ptr_d = gnt[ID_FETCH] ? ID_DATA : ID_FETCH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= ID_DATA;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory between fetch and data ports: grant in IDLE, one ACCESS cycle, registered response.
// Latency grant edge N -> rsp_valid in N+2; requesters hold req until gnt, one access per 2 cycles.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_BYTES = ARB_MEM_BYTES,
  parameter int AW        = ARB_AW,
  parameter int DW        = ARB_DW
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam logic [AW-1:0] MAX_ADDR = AW'(MEM_BYTES - 4);

  arb_state_e    state_q, state_d;
  req_meta_t     meta_q, meta_d;
  logic          mem_read_q, mem_read_d;
  logic          mem_write_q, mem_write_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wd_q, mem_wd_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_id_q, rsp_id_d;
  logic          rsp_err_q, rsp_err_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;

  logic [1:0]    gnt;
  logic          arb_en;
  logic          sel_fetch;
  logic          sel_we;
  logic          sel_legal;
  logic [AW-1:0] sel_addr;

  // Gating with rst_n keeps grants low while reset is asserted, even with requests pending.
  assign arb_en = (state_q == ST_IDLE) && rst_n;

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({bus.i_req, bus.d_req}),
    .en    (arb_en),
    .gnt   (gnt)
  );

  assign sel_fetch = gnt[ID_FETCH];
  assign sel_addr  = sel_fetch ? bus.i_addr : bus.d_addr;
  assign sel_we    = !sel_fetch && bus.d_we;
  assign sel_legal = word_aligned(sel_addr[1:0]) && (sel_addr <= MAX_ADDR);

  always_comb begin
    state_d     = state_q;
    meta_d      = meta_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wd_d    = mem_wd_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt != 2'b00) begin
          state_d     = ST_ACCESS;
          meta_d      = '{id: sel_fetch, we: sel_we, err: !sel_legal};
          mem_read_d  = sel_legal && !sel_we;
          mem_write_d = sel_legal && sel_we;
          // Illegal requests leave the memory bus untouched.
          if (sel_legal) begin
            mem_addr_d = sel_addr;
            if (sel_we) begin
              mem_wd_d = bus.d_wdata;
            end
          end
        end
      end
      ST_ACCESS: begin
        state_d     = ST_IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_id_d    = meta_q.id;
        rsp_err_d   = meta_q.err;
        rsp_rdata_d = (meta_q.err || meta_q.we) ? '0 : bus.mem_rd;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      meta_q      <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wd_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      meta_q      <= meta_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wd_q    <= mem_wd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign bus.i_gnt     = gnt[ID_FETCH];
  assign bus.d_gnt     = gnt[ID_DATA];
  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wd    = mem_wd_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus random traffic against a
// transaction-level reference model (1KB word memory, alternating priority, 2-cycle response).
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int MEM_BYTES = 1024;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_port_arbiter #(.MEM_BYTES(MEM_BYTES), .AW(32), .DW(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Memory device: combinational read, write on posedge; preload port used only when idle.
  logic [31:0] dev_mem [0:255];
  logic        pl_en;
  logic [7:0]  pl_idx;
  logic [31:0] pl_dat;
  assign bus.mem_rd = dev_mem[bus.mem_addr[9:2]];
  always @(posedge clk) begin
    if (bus.mem_write) dev_mem[bus.mem_addr[9:2]] <= bus.mem_wd;
    else if (pl_en)    dev_mem[pl_idx] <= pl_dat;
  end

  // Reference model state
  logic [31:0] ref_mem [0:255];
  int          cycle, last_gnt_cyc, acc_cyc, rsp_cyc;
  logic        last_winner;
  logic        acc_legal, acc_we;
  logic [31:0] acc_addr, acc_wd;
  logic        rsp_id_e, rsp_err_e;
  logic [31:0] rsp_rdata_e;
  logic        obs_i_gnt, obs_d_gnt, obs_rsp;
  int          n_checks, n_fail;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", tag, act, exp, cycle);
    end
  endtask

  task automatic model_reset();
    last_gnt_cyc = -100;
    acc_cyc      = -100;
    rsp_cyc      = -100;
    last_winner  = ID_FETCH;
  endtask

  // Called mid-cycle with inputs stable: compares every output against the model, then advances it.
  task automatic check_cycle();
    logic        exp_i, exp_d, g_we;
    logic [31:0] g_addr;
    exp_i = 1'b0;
    exp_d = 1'b0;
    if (last_gnt_cyc != cycle - 1) begin
      if (bus.i_req && bus.d_req) begin
        if (last_winner == ID_FETCH) exp_d = 1'b1;
        else                         exp_i = 1'b1;
      end else begin
        exp_i = bus.i_req;
        exp_d = bus.d_req;
      end
    end
    check_eq("i_gnt", 32'(bus.i_gnt), 32'(exp_i));
    check_eq("d_gnt", 32'(bus.d_gnt), 32'(exp_d));
    obs_i_gnt = bus.i_gnt;
    obs_d_gnt = bus.d_gnt;
    obs_rsp   = bus.rsp_valid;

    if (acc_cyc == cycle) begin
      check_eq("mem_read", 32'(bus.mem_read), 32'(acc_legal && !acc_we));
      check_eq("mem_write", 32'(bus.mem_write), 32'(acc_legal && acc_we));
      if (acc_legal) check_eq("mem_addr", bus.mem_addr, acc_addr);
      if (acc_legal && acc_we) check_eq("mem_wd", bus.mem_wd, acc_wd);
      rsp_rdata_e = (acc_legal && !acc_we) ? ref_mem[acc_addr[9:2]] : 32'd0;
      if (acc_legal && acc_we) ref_mem[acc_addr[9:2]] = acc_wd;
    end else begin
      check_eq("mem_read_idle", 32'(bus.mem_read), 32'd0);
      check_eq("mem_write_idle", 32'(bus.mem_write), 32'd0);
    end

    check_eq("rsp_valid", 32'(bus.rsp_valid), 32'(rsp_cyc == cycle));
    if (rsp_cyc == cycle) begin
      check_eq("rsp_id", 32'(bus.rsp_id), 32'(rsp_id_e));
      check_eq("rsp_err", 32'(bus.rsp_err), 32'(rsp_err_e));
      check_eq("rsp_rdata", bus.rsp_rdata, rsp_rdata_e);
    end

    if (exp_i || exp_d) begin
      g_addr       = exp_i ? bus.i_addr : bus.d_addr;
      g_we         = exp_d && bus.d_we;
      acc_legal    = (g_addr % 4 == 0) && (longint'(g_addr) + 4 <= longint'(MEM_BYTES));
      acc_we       = g_we;
      acc_addr     = g_addr;
      acc_wd       = bus.d_wdata;
      acc_cyc      = cycle + 1;
      rsp_cyc      = cycle + 2;
      rsp_id_e     = exp_i ? ID_FETCH : ID_DATA;
      rsp_err_e    = !acc_legal;
      last_gnt_cyc = cycle;
      last_winner  = rsp_id_e;
    end
    cycle++;
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    repeat (n) tick();
  endtask

  // Raises one request and holds it until granted (bounded); returns in the ACCESS cycle.
  task automatic port_op(input logic fetch, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd);
    logic got;
    got = 1'b0;
    if (fetch) begin
      bus.i_req = 1'b1; bus.i_addr = addr;
    end else begin
      bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wd;
    end
    for (int k = 0; k < 6 && !got; k++) begin
      tick();
      got = fetch ? obs_i_gnt : obs_d_gnt;
    end
    check_eq("op_granted", 32'(got), 32'd1);
    if (fetch) bus.i_req = 1'b0;
    else       bus.d_req = 1'b0;
  endtask

  task automatic check_all_zero();
    check_eq("rst_i_gnt", 32'(bus.i_gnt), 32'd0);
    check_eq("rst_d_gnt", 32'(bus.d_gnt), 32'd0);
    check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    check_eq("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    check_eq("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    check_eq("rst_mem_read", 32'(bus.mem_read), 32'd0);
    check_eq("rst_mem_write", 32'(bus.mem_write), 32'd0);
    check_eq("rst_mem_addr", bus.mem_addr, 32'd0);
    check_eq("rst_mem_wd", bus.mem_wd, 32'd0);
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    logic [31:0] a;
    r = $urandom_range(0, 9);
    case (r)
      0:       a = {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
      1:       a = 32'h400 + 32'($urandom_range(0, 64)) * 4;
      2:       a = $urandom;
      3, 4:    a = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      default: a = {22'd0, 4'd0, 4'($urandom_range(0, 15)), 2'b00};
    endcase
    return a;
  endfunction

  int rsp_cnt;
  logic b2b_rsp;

  initial begin
    n_checks = 0; n_fail = 0; cycle = 0;
    model_reset();
    obs_i_gnt = 1'b0; obs_d_gnt = 1'b0; obs_rsp = 1'b0;
    rst_n = 1'b0;
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    pl_en = 1'b0; pl_idx = '0; pl_dat = '0;

    // Fill memory while in reset; word 0x10 carries a known pattern.
    @(posedge clk); #1;
    for (int i = 0; i < 256; i++) begin
      pl_en  = 1'b1;
      pl_idx = 8'(i);
      pl_dat = (i == 4) ? 32'hDEADBEEF : $urandom;
      ref_mem[i] = pl_dat;
      @(posedge clk); #1;
    end
    pl_en = 1'b0;
    check_all_zero();
    rst_n = 1'b1;
    idle_cycles(2);

    // Single fetch with known data
    port_op(1'b1, 1'b0, 32'h10, 32'd0);
    idle_cycles(3);

    // Write then read back-to-back: read issued in the write's response cycle
    port_op(1'b0, 1'b1, 32'h20, 32'h12345678);
    tick();
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h20;
    tick();
    b2b_rsp = obs_rsp;
    check_eq("b2b_rsp_same_cycle", 32'(b2b_rsp), 32'd1);
    check_eq("b2b_gnt_same_cycle", 32'(obs_d_gnt), 32'd1);
    bus.d_req = 1'b0;
    idle_cycles(3);

    // Contention: both held; responses every other cycle
    bus.i_req = 1'b1; bus.i_addr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
    rsp_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (obs_rsp) rsp_cnt++;
      if (obs_i_gnt) bus.i_addr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      if (obs_d_gnt) begin
        bus.d_we = 1'($urandom_range(0, 1));
        bus.d_addr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        bus.d_wdata = $urandom;
      end
    end
    check_eq("contention_rsp_count", 32'(rsp_cnt), 32'd4);
    idle_cycles(3);

    // Alignment / range boundaries
    port_op(1'b0, 1'b0, 32'h22, 32'd0);  idle_cycles(2);
    port_op(1'b0, 1'b1, 32'h3FD, 32'h1); idle_cycles(2);
    port_op(1'b0, 1'b0, 32'h400, 32'd0); idle_cycles(2);
    port_op(1'b0, 1'b0, 32'h3FC, 32'd0); idle_cycles(2);
    port_op(1'b1, 1'b0, 32'hFFFF_FFFC, 32'd0); idle_cycles(2);

    // Random traffic, including requests dropped before grant
    for (int k = 0; k < 3000; k++) begin
      if (obs_i_gnt || !bus.i_req) begin
        bus.i_req  = 1'($urandom_range(0, 1));
        bus.i_addr = rand_addr();
      end else if ($urandom_range(0, 15) == 0) begin
        bus.i_req = 1'b0;
      end
      if (obs_d_gnt || !bus.d_req) begin
        bus.d_req   = 1'($urandom_range(0, 1));
        bus.d_we    = 1'($urandom_range(0, 1));
        bus.d_addr  = rand_addr();
        bus.d_wdata = $urandom;
      end else if ($urandom_range(0, 15) == 0) begin
        bus.d_req = 1'b0;
      end
      tick();
    end
    idle_cycles(3);

    // Reset in the middle of an ACCESS of a write: outputs clear at once, write is lost
    port_op(1'b0, 1'b1, 32'h40, 32'hA5A5_5A5A);
    bus.i_req = 1'b1; bus.d_req = 1'b1;
    rst_n = 1'b0;
    #1;
    check_all_zero();
    @(posedge clk); #1;
    check_all_zero();
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    model_reset();
    rst_n = 1'b1;
    idle_cycles(4);
    port_op(1'b0, 1'b0, 32'h40, 32'd0);
    idle_cycles(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cycle);
    $fatal(1, "watchdog");
  end

endmodule
